// File: rtl/bip_pkg.sv
// Shared definitions for the BIP debug path: FSM states, word geometry and
// a constant-foldable ceil(log2) helper.
package bip_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CAPT    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-load shift register that hands out a word one byte at a time,
// LSB first, with a byte counter that flags the final byte of the word.
module word_serializer
  import bip_pkg::*;
#(
  parameter int unsigned WIDTH = BYTES_PER_WORD * 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [7:0]       next_byte,
  output logic             last
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CW     = clog2(NBYTES) + 1;

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count_q;

  // Byte that becomes current after the next shift, and last-byte flag.
  // next_byte lets the owner register the following byte in the same edge
  // as the shift, keeping its byte output registered.
  always_comb begin
    shifted   = shift_q >> 8;
    next_byte = shifted[7:0];
    last      = (count_q == CW'(NBYTES - 1));
  end

  // Load a fresh word (clearing the byte count) or advance by one byte.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
      count_q <= '0;
    end else if (shift) begin
      shift_q <= shifted;
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/data_memory_dumper.sv
// Reads a contiguous window of data memory and streams it byte-by-byte,
// LSB first, to the UART transmitter through its start/done handshake.
module data_memory_dumper
  import bip_pkg::*;
#(
  parameter int unsigned RAM_WIDTH   = DATA_WIDTH,
  parameter int unsigned RAM_DEPTH   = 1024,
  parameter int unsigned COUNT_WIDTH = 11
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [RAM_WIDTH-1:0]   i_base_address,
  input  logic [COUNT_WIDTH-1:0] i_word_count,
  output logic                   o_mem_valid,
  output logic                   o_mem_read_enable,
  output logic                   o_mem_write_enable,
  output logic [RAM_WIDTH-1:0]   o_mem_address,
  input  logic [RAM_WIDTH-1:0]   i_mem_read_data,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [RAM_WIDTH-1:0]   ADDR_MASK   = RAM_WIDTH'(RAM_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(RAM_DEPTH);

  state_t                 state_q;
  logic [RAM_WIDTH-1:0]   base_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] index_q;

  logic [COUNT_WIDTH-1:0] index_inc;
  logic [COUNT_WIDTH-1:0] count_clamped;
  logic [RAM_WIDTH-1:0]   addr_start;
  logic [RAM_WIDTH-1:0]   addr_next;
  logic                   last_word;

  logic       ser_load;
  logic       ser_shift;
  logic [7:0] ser_next_byte;
  logic       ser_last;

  assign o_mem_write_enable = 1'b0;

  // Address arithmetic and count clamping. Addresses are registered on the
  // edge that enters REQ, so both the first address (from the live inputs)
  // and the following one (from the latched base) are formed here.
  always_comb begin
    index_inc     = index_q + 1'b1;
    count_clamped = (i_word_count > DEPTH_COUNT) ? DEPTH_COUNT : i_word_count;
    addr_start    = i_base_address & ADDR_MASK;
    addr_next     = (base_q + RAM_WIDTH'(index_inc)) & ADDR_MASK;
    last_word     = (index_inc == count_q);
    ser_load      = (state_q == ST_CAPT);
    ser_shift     = (state_q == ST_WAIT_TX) && i_tx_done;
  end

  word_serializer #(
    .WIDTH (RAM_WIDTH)
  ) u_word_serializer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .load      (ser_load),
    .load_data (i_mem_read_data),
    .shift     (ser_shift),
    .next_byte (ser_next_byte),
    .last      (ser_last)
  );

  // Dump sequencer. Outputs are registered, so each one is set on the edge
  // that enters the state in which it must be visible; the first byte of a
  // word is taken straight from the read data because the shift register
  // only loads on that same edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q           <= ST_IDLE;
      base_q            <= '0;
      count_q           <= '0;
      index_q           <= '0;
      o_mem_valid       <= 1'b0;
      o_mem_read_enable <= 1'b0;
      o_mem_address     <= '0;
      o_tx_data         <= '0;
      o_tx_start        <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
    end else begin
      o_mem_valid       <= 1'b0;
      o_mem_read_enable <= 1'b0;
      o_mem_address     <= '0;
      o_tx_start        <= 1'b0;
      o_done            <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            base_q  <= i_base_address;
            count_q <= count_clamped;
            index_q <= '0;
            o_busy  <= 1'b1;
            if (count_clamped == '0) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              state_q           <= ST_REQ;
              o_mem_valid       <= 1'b1;
              o_mem_read_enable <= 1'b1;
              o_mem_address     <= addr_start;
            end
          end
        end
        ST_REQ: begin
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          state_q    <= ST_SEND;
          o_tx_start <= 1'b1;
          o_tx_data  <= i_mem_read_data[7:0];
        end
        ST_SEND: begin
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            if (ser_last) begin
              if (last_word) begin
                state_q <= ST_DONE;
                o_done  <= 1'b1;
              end else begin
                index_q           <= index_inc;
                state_q           <= ST_REQ;
                o_mem_valid       <= 1'b1;
                o_mem_read_enable <= 1'b1;
                o_mem_address     <= addr_next;
              end
            end else begin
              state_q    <= ST_SEND;
              o_tx_start <= 1'b1;
              o_tx_data  <= ser_next_byte;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_dumper.md
Name: data_memory_dumper

Overview:
- Initiator on the data_memory port; the memory is the responder.
- On a start pulse, reads a contiguous window of data memory and serialises each word byte-by-byte, LSB first, to the UART transmitter through a start/done handshake.
- Sits between data_memory and uart_tx in the BIP debug path, so post-run memory contents can be dumped to the host.

Parameters:
- RAM_WIDTH, 32, data and address width; must be a multiple of 8.
- RAM_DEPTH, 1024, number of memory entries; must be a power of 2.
- COUNT_WIDTH, 11, width of the word-count input; equals log2(RAM_DEPTH)+1.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_reset  in  1  synchronous reset, active-low: logic resets on a posedge while i_reset=0.
- i_start  in  1  one-cycle pulse that starts a dump.
- i_base_address  in  RAM_WIDTH  first word address; sampled on i_start.
- i_word_count  in  COUNT_WIDTH  number of words to dump; sampled on i_start.
- o_mem_valid  out  1  memory access strobe.
- o_mem_read_enable  out  1  memory read request.
- o_mem_write_enable  out  1  always 0.
- o_mem_address  out  RAM_WIDTH  memory address.
- i_mem_read_data  in  RAM_WIDTH  registered memory read data.
- o_tx_data  out  8  byte to the transmitter.
- o_tx_start  out  1  one-cycle pulse; o_tx_data is valid in the same cycle.
- i_tx_done  in  1  transmitter byte-complete tick.
- o_busy  out  1  high from the cycle after an accepted i_start until DONE is left.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE, all outputs 0, address, word and byte counters cleared. This applies mid-operation too: an in-flight byte is abandoned and no o_done is produced.
- States: IDLE, REQ, CAPT, SEND, WAIT_TX, DONE.
- IDLE:
  - On i_start, latch the base address and count. Count = min(i_word_count, RAM_DEPTH).
  - Count 0: go to DONE. Otherwise set word index to 0 and go to REQ.
- REQ (one cycle):
  - Drive o_mem_valid=1, o_mem_read_enable=1.
  - o_mem_address = (base + index) mod RAM_DEPTH, upper bits 0. An address past RAM_DEPTH-1 wraps to 0.
  - Next state CAPT.
- CAPT (one cycle):
  - i_mem_read_data is valid here, because the memory registers read data at the REQ edge.
  - Load it into the shift register, clear the byte counter, go to SEND.
  - Read-to-capture latency is 1 cycle; o_mem_valid=0 in CAPT.
- SEND (one cycle):
  - o_tx_start=1, o_tx_data = shift[7:0]. Next state WAIT_TX.
- WAIT_TX:
  - Hold o_tx_data. On i_tx_done, shift right by 8 and increment the byte counter.
  - If the byte counter reaches RAM_WIDTH/8 and index+1 = count: go to DONE.
  - If the word is finished but more words remain: index+1, go to REQ.
  - Otherwise go to SEND.
  - i_tx_done is ignored in every other state, including SEND.
- DONE (one cycle): o_done=1, then IDLE. o_busy=0 in IDLE only.
- i_start outside IDLE is ignored; the inputs are not re-sampled.
- Throughput per word: 2 + (RAM_WIDTH/8) × (1 + tx latency) cycles.
- o_mem_address is 0 whenever not in REQ.
- Widths:
  - Address add is RAM_WIDTH bits, then masked to log2(RAM_DEPTH) bits.
  - Byte counter is log2(RAM_WIDTH/8)+1 bits.
  - Word index is COUNT_WIDTH bits.

Decomposition:
- Shared package bip_pkg holds:
  - state encoding localparams: ST_IDLE=0, ST_REQ=1, ST_CAPT=2, ST_SEND=3, ST_WAIT_TX=4, ST_DONE=5;
  - BYTES_PER_WORD = RAM_WIDTH/8;
  - a clog2 function.
- One sub-module is natural: word_serializer. It is a parallel-load shift register plus byte counter with load, shift and last outputs. It is instantiated once; the FSM and address generation stay in the top.

Test Plan:
Bench model: data_memory instance initialised with DRAM[i]=i, plus a uart_tx stub that returns i_tx_done N cycles after o_tx_start.
- Basic dump, N=3: base=5, count=2 -> bytes 05 00 00 00 06 00 00 00. o_mem_address is 5 then 6, one REQ cycle each. One o_done pulse after the 8th i_tx_done. o_mem_write_enable stays 0 throughout.
- Zero count: count=0 -> o_done two cycles after i_start, with no o_mem_valid and no o_tx_start.
- Wrap-around: base=1023, count=2 -> bytes FF 03 00 00 00 00 00 00, addresses 1023 then 0.
- Clamp and stall: count=2047 -> exactly 1024 words (4096 tx_start pulses). Also, an i_tx_done forced during SEND is ignored, and a 20-cycle tx delay still gives the correct byte order.
- Start while busy: a second i_start with base=100 during the first word -> ignored; addresses stay those of the first dump.
- Reset mid-operation: i_reset=0 for one posedge in WAIT_TX of word 1 -> next cycle all outputs 0 and state IDLE, no o_done. A fresh i_start then dumps correctly.
